// File: rtl/itcm_image_loader.sv
// Boot loader: packs a byte stream into memory words, writes them from address 0,
// optionally zero-fills the remainder, and holds the core in reset until finished.
module itcm_image_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter bit          BYTE_SWAP  = 1'b1,
  parameter bit          ZERO_FILL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           checksum
);

  localparam int unsigned LANES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SH_W   = LANE_W + 3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StFill, StDone} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LANE_W-1:0]       lane_q;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic                    pend_last_q;  // write in flight carries the final image word
  logic                    pend_ovf_q;   // write in flight fills DEPTH-1 with more image to come
  logic [SH_W-1:0]         ofs;
  logic [DATA_WIDTH-1:0]   asm_next;
  logic                    accept;
  logic                    word_done;

  // Merge the incoming byte into its lane of the word under assembly.
  always_comb begin
    ofs      = BYTE_SWAP ? {lane_q, 3'b000} : SH_W'(DATA_WIDTH - 8) - {lane_q, 3'b000};
    asm_next = asm_q | (DATA_WIDTH'(s_data) << ofs);
  end

  // Refuse bytes while the final or overflowing word is being written.
  assign s_ready   = (state_q == StLoad) && !(mem_we && (pend_last_q || pend_ovf_q));
  assign accept    = s_valid && s_ready;
  assign word_done = accept && (s_last || (lane_q == LAST_LANE));
  assign busy      = (state_q == StLoad) || (state_q == StFill);
  assign done      = (state_q == StDone);
  assign core_hold = (state_q != StDone);

  // Loader FSM with registered memory write port and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      pend_last_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err         <= 1'b0;
      word_count  <= '0;
      checksum    <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          mem_we <= 1'b0;
          if (start) begin
            state_q     <= StLoad;
            addr_q      <= '0;
            lane_q      <= '0;
            asm_q       <= '0;
            pend_last_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            err         <= 1'b0;
            word_count  <= '0;
            checksum    <= '0;
          end
        end
        StLoad: begin
          mem_we <= 1'b0;
          if (mem_we && pend_ovf_q) begin
            err     <= 1'b1;
            state_q <= StDone;
          end else if (mem_we && pend_last_q) begin
            if ((mem_addr == LAST_ADDR) || !ZERO_FILL) begin
              state_q <= StDone;
            end else begin
              // First fill write goes out right behind the last image word.
              state_q   <= StFill;
              mem_we    <= 1'b1;
              mem_addr  <= addr_q;
              mem_wdata <= '0;
              addr_q    <= addr_q + ADDR_ONE;
            end
          end
          if (accept) begin
            if (word_done) begin
              mem_we      <= 1'b1;
              mem_addr    <= addr_q;
              mem_wdata   <= asm_next;
              word_count  <= word_count + CNT_ONE;
              checksum    <= checksum + 32'(asm_next);
              addr_q      <= addr_q + ADDR_ONE;
              lane_q      <= '0;
              asm_q       <= '0;
              pend_last_q <= s_last;
              pend_ovf_q  <= (addr_q == LAST_ADDR) && !s_last;
            end else begin
              lane_q <= lane_q + LANE_ONE;
              asm_q  <= asm_next;
            end
          end
        end
        StFill: begin
          if (mem_addr == LAST_ADDR) begin
            mem_we  <= 1'b0;
            state_q <= StDone;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= '0;
            addr_q    <= addr_q + ADDR_ONE;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_itcm_image_loader.sv
// Self-checking bench for itcm_image_loader: three instances cover little-endian with fill,
// big-endian without fill, and a 4-word memory for overflow.
module tb_itcm_image_loader;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3], start[3], s_valid[3], s_last[3];
  logic [7:0]  s_data[3];
  logic        s_ready[3], mem_we[3], core_hold[3], busy[3], done[3], err[3];
  logic [31:0] mem_wdata[3], checksum[3];
  logic [3:0]  addr_a, addr_b;
  logic [1:0]  addr_c;
  logic [4:0]  wc_a, wc_b;
  logic [2:0]  wc_c;
  logic [31:0] maddr[3], wcnt[3];

  always_comb begin
    maddr[0] = 32'(addr_a);
    maddr[1] = 32'(addr_b);
    maddr[2] = 32'(addr_c);
    wcnt[0]  = 32'(wc_a);
    wcnt[1]  = 32'(wc_b);
    wcnt[2]  = 32'(wc_c);
  end

  itcm_image_loader #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .BYTE_SWAP(1), .ZERO_FILL(1))
  u_a (.clk(clk), .rst(rst[0]), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
       .s_last(s_last[0]), .s_ready(s_ready[0]), .mem_we(mem_we[0]), .mem_addr(addr_a),
       .mem_wdata(mem_wdata[0]), .core_hold(core_hold[0]), .busy(busy[0]), .done(done[0]),
       .err(err[0]), .word_count(wc_a), .checksum(checksum[0]));

  itcm_image_loader #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .BYTE_SWAP(0), .ZERO_FILL(0))
  u_b (.clk(clk), .rst(rst[1]), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
       .s_last(s_last[1]), .s_ready(s_ready[1]), .mem_we(mem_we[1]), .mem_addr(addr_b),
       .mem_wdata(mem_wdata[1]), .core_hold(core_hold[1]), .busy(busy[1]), .done(done[1]),
       .err(err[1]), .word_count(wc_b), .checksum(checksum[1]));

  itcm_image_loader #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2), .BYTE_SWAP(1), .ZERO_FILL(1))
  u_c (.clk(clk), .rst(rst[2]), .start(start[2]), .s_valid(s_valid[2]), .s_data(s_data[2]),
       .s_last(s_last[2]), .s_ready(s_ready[2]), .mem_we(mem_we[2]), .mem_addr(addr_c),
       .mem_wdata(mem_wdata[2]), .core_hold(core_hold[2]), .busy(busy[2]), .done(done[2]),
       .err(err[2]), .word_count(wc_c), .checksum(checksum[2]));

  // Write log: every cycle with mem_we high, tagged with its cycle index.
  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wlog[3][$];
  int  cyc = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_we[i] === 1'b1) begin
        wr_t e;
        e.cyc  = cyc;
        e.addr = int'(maddr[i]);
        e.data = mem_wdata[i];
        wlog[i].push_back(e);
      end
    end
    cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_mem[16], got_mem[16];
  logic [31:0] exp_cs;
  int          exp_words, exp_nwr, exp_acc, got_n;
  bit          exp_ovf;

  // Reference: the image as a list of words, cut at depth, then zeros when filling.
  task automatic model(input bit bs, input bit zf, input int depth);
    int n = stim.size();
    int words = (n + 3) / 4;
    exp_ovf = (words > depth);
    if (exp_ovf) words = depth;
    exp_words = words;
    exp_acc = exp_ovf ? depth * 4 : n;
    exp_cs = 32'h0;
    for (int a = 0; a < 16; a++) exp_mem[a] = SENT;
    for (int w = 0; w < words; w++) begin
      logic [31:0] v = 32'h0;
      for (int k = 0; k < 4; k++) begin
        int idx = 4 * w + k;
        if (idx < n) begin
          if (bs) v = v + (32'(stim[idx]) << (8 * k));
          else    v = v + (32'(stim[idx]) << (24 - 8 * k));
        end
      end
      exp_mem[w] = v;
      exp_cs = exp_cs + v;
    end
    exp_nwr = words;
    if (zf && !exp_ovf) begin
      for (int a = words; a < depth; a++) exp_mem[a] = 32'h0;
      exp_nwr = depth;
    end
  endtask

  task automatic build_got(input int i, input int base);
    for (int a = 0; a < 16; a++) got_mem[a] = SENT;
    got_n = wlog[i].size() - base;
    for (int k = base; k < wlog[i].size(); k++)
      if (wlog[i][k].addr < 16) got_mem[wlog[i][k].addr] = wlog[i][k].data;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Sends stim; s_last on the final byte when with_last. Stops at a byte not taken in 40 cycles.
  task automatic stream(input int i, input bit gaps, input bit pokes, input bit with_last,
                        output int acc);
    acc = 0;
    for (int n = 0; n < stim.size(); n++) begin
      bit got;
      int t;
      if (gaps) begin
        int g = $urandom_range(0, 3);
        repeat (g) begin
          start[i] = pokes && ($urandom_range(0, 1) == 1);
          @(negedge clk);
        end
        start[i] = 1'b0;
      end
      s_valid[i] = 1'b1;
      s_data[i]  = stim[n];
      s_last[i]  = with_last && (n == stim.size() - 1);
      got = 1'b0;
      t = 0;
      while (!got && t < 40) begin
        got = (s_ready[i] === 1'b1);
        @(negedge clk);
        t++;
      end
      s_valid[i] = 1'b0;
      s_last[i]  = 1'b0;
      if (!got) break;
      acc++;
    end
  endtask

  task automatic wait_done(input int i, output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = -1;
    for (int t = 0; t < 200; t++) begin
      if (done[i] === 1'b1) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({s_ready[i], mem_we[i], busy[i], done[i], err[i], core_hold[i]} !== 6'b000001) begin
        failures++;
        $display("FAIL reset_flags inst%0d: got %b want 000001", i,
                 {s_ready[i], mem_we[i], busy[i], done[i], err[i], core_hold[i]});
      end
      checks++;
      if (wcnt[i] !== 32'h0 || checksum[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_counts inst%0d: got wc=%h cs=%h want 0", i, wcnt[i], checksum[i]);
      end
      checks++;
      if (maddr[i] !== 32'h0 || mem_wdata[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_mem inst%0d: got a=%h d=%h want 0", i, maddr[i], mem_wdata[i]);
      end
    end
  endtask

  task automatic test_le_fill;
    int base, acc, dcyc;
    bit ok, bad;
    stim = {};
    for (int n = 1; n <= 8; n++) stim.push_back(8'(n));
    base = wlog[0].size();
    pulse_start(0);
    checks++;
    if (core_hold[0] !== 1'b1 || busy[0] !== 1'b1 || s_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL le_load_entry: got hold=%b busy=%b rdy=%b want 111",
               core_hold[0], busy[0], s_ready[0]);
    end
    stream(0, 1'b0, 1'b0, 1'b1, acc);
    wait_done(0, dcyc, ok);
    model(1'b1, 1'b1, 16);
    build_got(0, base);
    checks++;
    if (!ok || acc != exp_acc) begin
      failures++;
      $display("FAIL le_done: got done=%0d acc=%0d want 1 %0d", ok, acc, exp_acc);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL le_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (got_mem[0] !== 32'h04030201 || got_mem[1] !== 32'h08070605) begin
      failures++;
      $display("FAIL le_words: got %h %h want 04030201 08070605", got_mem[0], got_mem[1]);
    end
    checks++;
    if (wcnt[0] !== 32'd2 || checksum[0] !== 32'h0C0A0806) begin
      failures++;
      $display("FAIL le_status: got wc=%0d cs=%h want 2 0c0a0806", wcnt[0], checksum[0]);
    end
    bad = (got_n != exp_nwr);
    for (int k = 0; k < got_n && !bad; k++) begin
      if (wlog[0][base + k].addr != k) bad = 1'b1;
      if (k > exp_words && wlog[0][base + k].cyc != wlog[0][base + k - 1].cyc + 1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL le_write_seq: got %0d writes want %0d sequential, fill consecutive",
               got_n, exp_nwr);
    end
    checks++;
    if (got_n > 0 && dcyc != wlog[0][base + got_n - 1].cyc + 1) begin
      failures++;
      $display("FAIL le_done_cycle: got %0d want %0d", dcyc, wlog[0][base + got_n - 1].cyc + 1);
    end
    checks++;
    if (core_hold[0] !== 1'b0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
      failures++;
      $display("FAIL le_final_flags: got hold=%b busy=%b err=%b want 000",
               core_hold[0], busy[0], err[0]);
    end
  endtask

  task automatic test_be_nofill;
    int base, acc, dcyc;
    bit ok, bad;
    stim = {};
    for (int n = 1; n <= 8; n++) stim.push_back(8'(n));
    base = wlog[1].size();
    pulse_start(1);
    stream(1, 1'b0, 1'b0, 1'b1, acc);
    wait_done(1, dcyc, ok);
    model(1'b0, 1'b0, 16);
    build_got(1, base);
    checks++;
    if (!ok || acc != exp_acc) begin
      failures++;
      $display("FAIL be_done: got done=%0d acc=%0d want 1 %0d", ok, acc, exp_acc);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL be_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (got_mem[0] !== 32'h01020304 || got_mem[1] !== 32'h05060708) begin
      failures++;
      $display("FAIL be_words: got %h %h want 01020304 05060708", got_mem[0], got_mem[1]);
    end
    bad = (got_n != 2);
    for (int k = 0; k < got_n && !bad; k++) if (wlog[1][base + k].addr != k) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL be_write_seq: got %0d writes want 2", got_n);
    end
    checks++;
    if (got_n > 0 && dcyc != wlog[1][base + got_n - 1].cyc + 1) begin
      failures++;
      $display("FAIL be_done_cycle: got %0d want %0d", dcyc, wlog[1][base + got_n - 1].cyc + 1);
    end
    checks++;
    if (wcnt[1] !== 32'(exp_words) || checksum[1] !== exp_cs) begin
      failures++;
      $display("FAIL be_status: got wc=%0d cs=%h want %0d %h", wcnt[1], checksum[1],
               exp_words, exp_cs);
    end
  endtask

  task automatic test_partial;
    int base, acc, dcyc;
    bit ok;
    stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    base = wlog[0].size();
    pulse_start(0);
    stream(0, 1'b0, 1'b0, 1'b1, acc);
    wait_done(0, dcyc, ok);
    model(1'b1, 1'b1, 16);
    build_got(0, base);
    checks++;
    if (!ok || acc != 5) begin
      failures++;
      $display("FAIL part_done: got done=%0d acc=%0d want 1 5", ok, acc);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL part_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (got_mem[1] !== 32'h000000EE || wcnt[0] !== 32'd2 || checksum[0] !== 32'hDDCCBC98) begin
      failures++;
      $display("FAIL part_status: got m1=%h wc=%0d cs=%h want 000000ee 2 ddccbc98",
               got_mem[1], wcnt[0], checksum[0]);
    end
  endtask

  task automatic test_overflow;
    int base, acc, dcyc;
    bit ok, bad;
    stim = {};
    for (int n = 0; n < 20; n++) stim.push_back(8'($urandom));
    base = wlog[2].size();
    pulse_start(2);
    stream(2, 1'b0, 1'b0, 1'b1, acc);
    wait_done(2, dcyc, ok);
    model(1'b1, 1'b1, 4);
    build_got(2, base);
    checks++;
    if (acc != exp_acc || acc != 16) begin
      failures++;
      $display("FAIL ovf_accepted: got %0d want 16", acc);
    end
    checks++;
    if (!ok || err[2] !== 1'b1 || s_ready[2] !== 1'b0 || core_hold[2] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flags: got done=%0d err=%b rdy=%b hold=%b want 1 1 0 0",
               ok, err[2], s_ready[2], core_hold[2]);
    end
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL ovf_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    bad = (got_n != 4);
    for (int k = 0; k < got_n && !bad; k++) if (wlog[2][base + k].addr != k) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL ovf_write_seq: got %0d writes want 4", got_n);
    end
    checks++;
    if (wcnt[2] !== 32'd4 || checksum[2] !== exp_cs) begin
      failures++;
      $display("FAIL ovf_status: got wc=%0d cs=%h want 4 %h", wcnt[2], checksum[2], exp_cs);
    end
  endtask

  task automatic test_back_to_back;
    int base, acc, dcyc;
    bit ok;
    stim = {};
    for (int n = 0; n < 16; n++) stim.push_back(8'($urandom));
    base = wlog[0].size();
    pulse_start(0);
    stream(0, 1'b1, 1'b1, 1'b1, acc);
    wait_done(0, dcyc, ok);
    model(1'b1, 1'b1, 16);
    build_got(0, base);
    checks++;
    if (!ok || acc != 16 || got_n != 16) begin
      failures++;
      $display("FAIL bp_done: got done=%0d acc=%0d writes=%0d want 1 16 16", ok, acc, got_n);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL bp_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (wcnt[0] !== 32'd4 || checksum[0] !== exp_cs) begin
      failures++;
      $display("FAIL bp_status: got wc=%0d cs=%h want 4 %h", wcnt[0], checksum[0], exp_cs);
    end
  endtask

  task automatic test_mid_reset;
    int base, acc, dcyc;
    bit ok;
    stim = {};
    for (int n = 0; n < 6; n++) stim.push_back(8'($urandom));
    pulse_start(0);
    stream(0, 1'b0, 1'b0, 1'b0, acc);
    rst[0] = 1'b1;
    #1;
    checks++;
    if ({s_ready[0], mem_we[0], busy[0], done[0], err[0], core_hold[0]} !== 6'b000001 ||
        wcnt[0] !== 32'h0 || checksum[0] !== 32'h0 || maddr[0] !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: got flags=%b wc=%0d cs=%h a=%h want 000001 0 0 0",
               {s_ready[0], mem_we[0], busy[0], done[0], err[0], core_hold[0]},
               wcnt[0], checksum[0], maddr[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready[0] !== 1'b0 || core_hold[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: got rdy=%b hold=%b busy=%b want 0 1 0",
               s_ready[0], core_hold[0], busy[0]);
    end
    stim = {};
    for (int n = 0; n < 12; n++) stim.push_back(8'($urandom));
    base = wlog[0].size();
    pulse_start(0);
    stream(0, 1'b0, 1'b0, 1'b1, acc);
    wait_done(0, dcyc, ok);
    model(1'b1, 1'b1, 16);
    build_got(0, base);
    checks++;
    if (!ok || acc != 12 || core_hold[0] !== 1'b0) begin
      failures++;
      $display("FAIL mr_done: got done=%0d acc=%0d hold=%b want 1 12 0", ok, acc, core_hold[0]);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (got_mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL mr_mem[%0d]: got %h want %h", a, got_mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (wcnt[0] !== 32'd3 || checksum[0] !== exp_cs) begin
      failures++;
      $display("FAIL mr_status: got wc=%0d cs=%h want 3 %h", wcnt[0], checksum[0], exp_cs);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]     = 1'b1;
      start[i]   = 1'b0;
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
      s_last[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_le_fill();
    test_be_nofill();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itcm_image_loader.md
Name: itcm_image_loader

Overview:
- Synthesizable boot loader that fills the instruction memory (ITCM BRAM) from a byte stream, for example from a UART receiver or a debug link.
- Assembles bytes into DATA_WIDTH words with selectable byte order.
- Writes the words sequentially from address 0 and optionally zero-fills the rest of the memory.
- Holds the core in reset until the image is complete, then reports a word count and a checksum.

Parameters:
DATA_WIDTH, 32, memory word width; multiple of 8, minimum 8
DEPTH, 16384, memory depth in words; must be at least 2
ADDR_WIDTH, 14, memory address width; must equal clog2(DEPTH)
BYTE_SWAP, 1, 1: first stream byte of a word lands in bits [7:0] (little-endian); 0: first byte lands in the MS byte
ZERO_FILL, 1, 1: after s_last, write zero to every remaining address up to DEPTH-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a load
s_valid  in  1  stream byte valid
s_data  in  8  stream byte
s_last  in  1  qualifies the final byte of the image
s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid and s_ready are both high
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
core_hold  out  1  keeps the core in reset while high
busy  out  1  high in LOAD or FILL
done  out  1  high in DONE
err  out  1  image exceeded DEPTH words
word_count  out  ADDR_WIDTH+1  number of image words written (fill words not counted)
checksum  out  32  wrapping 32-bit sum of image words, zero-extended or truncated to 32 bits; fill words not counted

Behaviour:
- Reset values (rst high, asynchronous): state IDLE, core_hold=1, all other outputs 0, internal byte lane index=0, assembly register=0.
- States: IDLE, LOAD, FILL, DONE.
- IDLE:
  - s_ready=0.
  - start -> LOAD; clears the address, lane index, assembly register, word_count, checksum and err; sets core_hold=1.
- LOAD:
  - s_ready=1 unless the overflow condition below applies.
  - Each accepted byte goes into lane k (k = 0..DATA_WIDTH/8-1): bit offset 8k when BYTE_SWAP=1, offset DATA_WIDTH-8-8k when BYTE_SWAP=0.
  - A word completes when the last lane is accepted or s_last is accepted.
  - On completion the next cycle carries the write: mem_we=1, mem_addr=current address, mem_wdata=assembled word. Unfilled lanes of a partial word are 0.
  - On that same edge: word_count+1, checksum+=word, address+1, lane index and assembly register cleared.
  - Write latency is one cycle. Byte acceptance continues in the write cycle with no bubble, giving full throughput of 1 byte/cycle.
  - s_valid low: no state change; gaps of any length are allowed.
- s_last handling:
  - If the final word was written at address DEPTH-1 or ZERO_FILL=0 -> DONE after the write.
  - Otherwise -> FILL.
- Overflow:
  - After the word at DEPTH-1 is written without s_last, s_ready goes low in the write cycle; that cycle does not accept.
  - err is set, the state goes to DONE, and no further bytes are ever accepted in this load.
- FILL:
  - mem_we=1 with mem_wdata=0 every cycle, addresses from (last image address+1) to DEPTH-1 inclusive, then DONE.
  - s_ready=0.
- DONE:
  - done=1, core_hold=0, busy=0.
  - word_count, checksum and err hold their values.
  - start -> LOAD (restart, core_hold back to 1).
- start while LOAD or FILL is ignored.
- mem_we is 0 in all cycles other than the write cycles described above.
- rst asserted mid-LOAD or mid-FILL: immediate return to reset values; memory contents are left undefined; a new start is required.

Test Plan:
1. BYTE_SWAP=1, stream 01 02 03 04 05 06 07 08 with s_last on 08 -> mem[0]=04030201, mem[1]=08070605, word_count=2, checksum=0C0A0806; with DEPTH=16, addresses 2..15 written 0 over 14 consecutive cycles, then done=1 and core_hold=0.
2. BYTE_SWAP=0, same stream, ZERO_FILL=0 -> mem[0]=01020304, mem[1]=05060708; DONE in the cycle after the second write; no fill writes.
3. Partial word: AA BB CC DD EE with s_last on EE, BYTE_SWAP=1 -> mem[1]=000000EE, word_count=2, checksum=DDCCBBAA+000000EE=DDCCBC98.
4. Overflow: DEPTH=4, 20 bytes streamed -> 4 writes (addresses 0..3), s_ready low after the 16th byte, err=1, done=1, word_count=4.
5. Back-pressure: s_valid toggled randomly over 4 words -> identical memory contents and checksum to the continuous case; start pulses during LOAD have no effect.
6. rst pulsed after 6 bytes -> all outputs return to reset values, core_hold=1; a following start plus the full image -> correct contents and done=1.
